mc_ctrl_fsm: RTL and testbench

Multi-cycle MIPS-subset control unit. It decodes the latched instruction and sequences every datapath control strobe cycle by cycle. It drives the register-file wrapper (write_reg, regdst, memtoreg), the PC module (write_pc, pcsource), the IR/memory path and the ALU operand muxes. It is a Moore FSM, except that the branch PC-write is qualified by the ALU zero flag.

---
 rtl/mc_ctrl_fsm.sv | 190 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control unit: decodes the latched instruction and
// sequences the datapath strobes state by state (Moore, except branch PC write).
module mc_ctrl_fsm #(
  parameter int unsigned STATE_W = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ir_data,
  input  logic               zero,
  output logic               write_pc,
  output logic [1:0]         pcsource,
  output logic               write_ir,
  output logic               iord,
  output logic               write_mem,
  output logic               write_reg,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [2:0]         alu_ctrl,
  output logic [STATE_W-1:0] state,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_cnt
);

  typedef enum logic [STATE_W-1:0] {
    S_IF  = STATE_W'(0),
    S_ID  = STATE_W'(1),
    S_MA  = STATE_W'(2),
    S_MR  = STATE_W'(3),
    S_MW  = STATE_W'(4),
    S_WBM = STATE_W'(5),
    S_EXR = STATE_W'(6),
    S_WBR = STATE_W'(7),
    S_BR  = STATE_W'(8),
    S_JMP = STATE_W'(9),
    S_EXI = STATE_W'(10),
    S_WBI = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     st;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       op_ok;
  logic       unused_bits;

  assign opcode      = ir_data[31:26];
  assign funct       = ir_data[5:0];
  assign unused_bits = ^ir_data[25:6];
  assign state       = st;

  // Opcode legality check used by ID for the illegal pulse
  always_comb begin
    op_ok = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end

  // R-type funct decode into ALU operation and legality
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_AND;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // State sequencing and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IF;
      instr_cnt <= '0;
    end else begin
      case (st)
        S_IF: st <= S_ID;
        S_ID: begin
          case (opcode)
            OP_RTYPE:      st <= S_EXR;
            OP_LW, OP_SW:  st <= S_MA;
            OP_BEQ, OP_BNE: st <= S_BR;
            OP_J:          st <= S_JMP;
            OP_ADDI:       st <= S_EXI;
            default:       st <= S_IF;
          endcase
        end
        S_MA:  st <= (opcode == OP_LW) ? S_MR : S_MW;
        S_MR:  st <= S_WBM;
        S_EXR: st <= funct_ok ? S_WBR : S_IF;
        S_EXI: st <= S_WBI;
        S_WBR, S_WBM, S_MW, S_BR, S_JMP, S_WBI: begin
          st        <= S_IF;
          instr_cnt <= instr_cnt + CNT_W'(1);
        end
        default: st <= S_IF;
      endcase
    end
  end

  // Per-state strobe decode; ir_data changes on the edge into ID, so the
  // decode-dependent outputs are taken from the live state, not pre-registered
  always_comb begin
    write_pc  = 1'b0;
    pcsource  = 2'b00;
    write_ir  = 1'b0;
    iord      = 1'b0;
    write_mem = 1'b0;
    write_reg = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    alu_ctrl  = ALU_AND;
    illegal   = 1'b0;
    if (!rst) begin
      case (st)
        S_IF: begin
          write_ir = 1'b1;
          alusrcb  = 2'b01;
          alu_ctrl = ALU_ADD;
          write_pc = 1'b1;
        end
        S_ID: begin
          alusrcb  = 2'b11;
          alu_ctrl = ALU_ADD;
          illegal  = ~op_ok;
        end
        S_EXR: begin
          alusrca  = 1'b1;
          alu_ctrl = funct_alu;
          illegal  = ~funct_ok;
        end
        S_WBR: begin
          write_reg = 1'b1;
          regdst    = 1'b1;
        end
        S_MA, S_EXI: begin
          alusrca  = 1'b1;
          alusrcb  = 2'b10;
          alu_ctrl = ALU_ADD;
        end
        S_MR: iord = 1'b1;
        S_WBM: begin
          write_reg = 1'b1;
          memtoreg  = 1'b1;
        end
        S_MW: begin
          iord      = 1'b1;
          write_mem = 1'b1;
        end
        S_BR: begin
          alusrca  = 1'b1;
          alu_ctrl = ALU_SUB;
          pcsource = 2'b01;
          write_pc = (opcode == OP_BNE) ? ~zero : zero;
        end
        S_JMP: begin
          pcsource = 2'b10;
          write_pc = 1'b1;
        end
        S_WBI: write_reg = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir_data;
  logic        zero;
  logic        write_pc;
  logic [1:0]  pcsource;
  logic        write_ir;
  logic        iord;
  logic        write_mem;
  logic        write_reg;
  logic        regdst;
  logic        memtoreg;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] instr_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .ir_data(ir_data), .zero(zero),
    .write_pc(write_pc), .pcsource(pcsource), .write_ir(write_ir),
    .iord(iord), .write_mem(write_mem), .write_reg(write_reg),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .alu_ctrl(alu_ctrl), .state(state),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );

  // Packed view of every control output plus state, for whole-vector checks
  logic [19:0] obs;
  assign obs = {write_pc, pcsource, write_ir, iord, write_mem, write_reg,
                regdst, memtoreg, alusrca, alusrcb, alu_ctrl, illegal, state};

  function automatic logic [19:0] ov(
    input logic [3:0] st, input logic wpc, input logic [1:0] pcs,
    input logic wir, input logic ird, input logic wmem, input logic wreg,
    input logic rdst, input logic m2r, input logic asa, input logic [1:0] asb,
    input logic [2:0] alu, input logic ill);
    return {wpc, pcs, wir, ird, wmem, wreg, rdst, m2r, asa, asb, alu, ill, st};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_out(input string tag, input logic [19:0] e);
    chk(tag, 32'(obs), 32'(e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [19:0] v_if, v_id, v_id_ill, v_ma, v_mr, v_wbm, v_exr_sub, v_wbr;
  logic [19:0] v_br_t, v_br_n, v_mw, v_jmp, v_exi, v_wbi, v_mw_rst;

  initial begin
    //           st     wpc pcs   wir iord wmem wreg rdst m2r asa asb    alu     ill
    v_if      = ov(4'd0,  1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 0);
    v_id      = ov(4'd1,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 0);
    v_id_ill  = ov(4'd1,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 1);
    v_ma      = ov(4'd2,  0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0);
    v_mr      = ov(4'd3,  0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    v_mw      = ov(4'd4,  0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    v_mw_rst  = ov(4'd4,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    v_wbm     = ov(4'd5,  0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 0);
    v_exr_sub = ov(4'd6,  0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 0);
    v_wbr     = ov(4'd7,  0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000, 0);
    v_br_t    = ov(4'd8,  1, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 0);
    v_br_n    = ov(4'd8,  0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 0);
    v_jmp     = ov(4'd9,  1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    v_exi     = ov(4'd10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0);
    v_wbi     = ov(4'd11, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 0);

    rst = 1'b1; zero = 1'b0; ir_data = 32'h0;

    // Reset held for two clocks
    step();
    chk_out("rst1_outs", 20'h0);
    chk("rst1_cnt", instr_cnt, 32'd0);
    step();
    chk_out("rst2_outs", 20'h0);
    chk("rst2_cnt", instr_cnt, 32'd0);
    rst = 1'b0;
    #1;
    chk_out("post_rst_if", v_if);

    // lw: IF ID MA MR WBM
    ir_data = 32'h8C220004;
    step(); chk_out("lw_id", v_id);
    step(); chk_out("lw_ma", v_ma);
    step(); chk_out("lw_mr", v_mr);
    step(); chk_out("lw_wbm", v_wbm);
    chk("lw_cnt_wbm", instr_cnt, 32'd0);
    step(); chk_out("lw_if", v_if);
    chk("lw_cnt", instr_cnt, 32'd1);

    // R-type sub: IF ID EXR WBR
    ir_data = 32'h00432022;
    step(); chk_out("sub_id", v_id);
    step(); chk_out("sub_exr", v_exr_sub);
    step(); chk_out("sub_wbr", v_wbr);
    step(); chk_out("sub_if", v_if);
    chk("sub_cnt", instr_cnt, 32'd2);

    // beq: write_pc follows zero in BR
    ir_data = 32'h10220003;
    step(); chk_out("beq_id", v_id);
    step(); zero = 1'b1; #1; chk_out("beq_taken", v_br_t);
    zero = 1'b0; #1; chk_out("beq_not", v_br_n);
    step(); chk_out("beq_if", v_if);
    chk("beq_cnt", instr_cnt, 32'd3);

    // bne: write_pc follows ~zero in BR
    ir_data = 32'h14220003;
    step(); chk_out("bne_id", v_id);
    step(); zero = 1'b0; #1; chk_out("bne_taken", v_br_t);
    zero = 1'b1; #1; chk_out("bne_not", v_br_n);
    zero = 1'b0;
    step(); chk_out("bne_if", v_if);
    chk("bne_cnt", instr_cnt, 32'd4);

    // Illegal opcode: pulse in ID, back to IF, not counted
    ir_data = 32'hFC000000;
    step(); chk_out("ill_op_id", v_id_ill);
    step(); chk_out("ill_op_if", v_if);
    chk("ill_op_cnt", instr_cnt, 32'd4);

    // Illegal funct: pulse in EXR, no register write
    ir_data = 32'h0000003F;
    step(); chk_out("ill_fn_id", v_id);
    step();
    chk("ill_fn_state", 32'(state), 32'd6);
    chk("ill_fn_pulse", 32'(illegal), 32'd1);
    chk("ill_fn_wreg", 32'(write_reg), 32'd0);
    step(); chk_out("ill_fn_if", v_if);
    chk("ill_fn_cnt", instr_cnt, 32'd4);

    // addi: IF ID EXI WBI
    ir_data = 32'h20220005;
    step(); chk_out("addi_id", v_id);
    step(); chk_out("addi_exi", v_exi);
    step(); chk_out("addi_wbi", v_wbi);
    step(); chk_out("addi_if", v_if);
    chk("addi_cnt", instr_cnt, 32'd5);

    // sw aborted by reset in MW
    ir_data = 32'hAC220008;
    step(); chk_out("sw_id", v_id);
    step(); chk_out("sw_ma", v_ma);
    step(); chk_out("sw_mw", v_mw);
    rst = 1'b1; #1;
    chk_out("sw_mw_rst", v_mw_rst);
    step();
    chk("sw_rst_state", 32'(state), 32'd0);
    chk("sw_rst_cnt", instr_cnt, 32'd0);
    rst = 1'b0; #1;
    chk_out("sw_rst_if", v_if);

    // Counter wrap through a jump
    force dut.instr_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.instr_cnt;
    ir_data = 32'h08000010;
    step(); chk_out("j_id", v_id);
    step(); chk_out("j_jmp", v_jmp);
    chk("j_cnt_pre", instr_cnt, 32'hFFFF_FFFF);
    step(); chk_out("j_if", v_if);
    chk("j_cnt_wrap", instr_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
